// File: rtl/wb_pkg.sv
// Shared encodings, widths and the alignment rule for the writeback stage.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_RSVD = 2'b11
    } wbSel_e;

    typedef enum logic [2:0] {
        LD_LW  = 3'b000,
        LD_LB  = 3'b001,
        LD_LBU = 3'b010,
        LD_LH  = 3'b011,
        LD_LHU = 3'b100
    } ldType_e;

    // Only memory-sourced results can fault; unknown load types behave as LW.
    function automatic logic isMisaligned(input logic [1:0] wbSel,
                                          input logic [2:0] ldType,
                                          input logic [1:0] addrLo);
        logic err;
        err = 1'b0;
        if (wbSel != WB_MEM) begin
            err = 1'b0;
        end else begin
            case (ldType)
                LD_LB, LD_LBU: err = 1'b0;
                LD_LH, LD_LHU: err = addrLo[0];
                default:       err = (addrLo != 2'b00);
            endcase
        end
        return err;
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-to-WB pipeline bus plus register-file write port and decode bypass tag.
interface writeback_stage_if;
    import wb_pkg::*;

    logic              InValid;
    logic              Stall;
    logic              Flush;
    logic              InRegWr;
    logic [REG_W-1:0]  InRW;
    logic [1:0]        InWbSel;
    logic [2:0]        InLdType;
    logic [1:0]        InAddrLo;
    logic [DATA_W-1:0] InAluResult;
    logic [DATA_W-1:0] InMemData;
    logic [DATA_W-1:0] InPcPlus8;

    logic [DATA_W-1:0] BusW;
    logic [REG_W-1:0]  RW;
    logic              RegWr;
    logic              FwdValid;
    logic [REG_W-1:0]  FwdRW;
    logic              AlignErr;
    logic [31:0]       RetireCount;

    modport master (
        output InValid, Stall, Flush, InRegWr, InRW, InWbSel, InLdType, InAddrLo,
               InAluResult, InMemData, InPcPlus8,
        input  BusW, RW, RegWr, FwdValid, FwdRW, AlignErr, RetireCount
    );

    modport slave (
        input  InValid, Stall, Flush, InRegWr, InRW, InWbSel, InLdType, InAddrLo,
               InAluResult, InMemData, InPcPlus8,
        output BusW, RW, RegWr, FwdValid, FwdRW, AlignErr, RetireCount
    );

endinterface

// File: rtl/load_extender.sv
// Big-endian byte/halfword extraction with sign or zero extension for loads.
module load_extender
    import wb_pkg::*;
(
    input  logic [DATA_W-1:0] memData,
    input  logic [2:0]        ldType,
    input  logic [1:0]        addrLo,
    output logic [DATA_W-1:0] loadData
);

    logic [7:0]  byteS;
    logic [15:0] halfS;

    // Lane select: address 00 is the most significant byte.
    always_comb begin
        byteS = 8'h00;
        case (addrLo)
            2'b00:   byteS = memData[31:24];
            2'b01:   byteS = memData[23:16];
            2'b10:   byteS = memData[15:8];
            default: byteS = memData[7:0];
        endcase
        if (addrLo[1]) begin
            halfS = memData[15:0];
        end else begin
            halfS = memData[31:16];
        end
    end

    // Extension by load type.
    always_comb begin
        loadData = memData;
        case (ldType)
            LD_LB:   loadData = {{24{byteS[7]}}, byteS};
            LD_LBU:  loadData = {24'h000000, byteS};
            LD_LH:   loadData = {{16{halfS[15]}}, halfS};
            LD_LHU:  loadData = {16'h0000, halfS};
            default: loadData = memData;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback pipeline stage: result select, load extension, one-shot register
// write, bypass tag, misalignment pulse and retire counter.
module writeback_stage
    import wb_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    writeback_stage_if.slave wb
);

    logic [DATA_W-1:0] loadDataS;
    logic [DATA_W-1:0] selDataS;
    logic              misalignS;
    logic              wrOkS;

    logic              validR;
    logic              writtenR;
    logic [DATA_W-1:0] busWR;
    logic [REG_W-1:0]  rwR;
    logic              regWrR;
    logic              fwdValidR;
    logic [REG_W-1:0]  fwdRwR;
    logic              alignErrR;
    logic [31:0]       retireCountR;

    load_extender uExt (
        .memData  (wb.InMemData),
        .ldType   (wb.InLdType),
        .addrLo   (wb.InAddrLo),
        .loadData (loadDataS)
    );

    // Result source mux; the reserved encoding falls back to the ALU result.
    always_comb begin
        selDataS = wb.InAluResult;
        case (wb.InWbSel)
            WB_MEM:  selDataS = loadDataS;
            WB_LINK: selDataS = wb.InPcPlus8;
            default: selDataS = wb.InAluResult;
        endcase
    end

    assign misalignS = isMisaligned(wb.InWbSel, wb.InLdType, wb.InAddrLo);
    assign wrOkS     = wb.InRegWr & (wb.InRW != 5'd0) & ~misalignS;

    // Stage register: flush beats stall; a stalled instruction never writes twice.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            validR       <= 1'b0;
            writtenR     <= 1'b0;
            busWR        <= 32'h0000_0000;
            rwR          <= 5'd0;
            regWrR       <= 1'b0;
            fwdValidR    <= 1'b0;
            fwdRwR       <= 5'd0;
            alignErrR    <= 1'b0;
            retireCountR <= 32'h0000_0000;
        end else if (wb.Flush || (!wb.Stall && !wb.InValid)) begin
            validR    <= 1'b0;
            writtenR  <= 1'b0;
            busWR     <= 32'h0000_0000;
            rwR       <= 5'd0;
            regWrR    <= 1'b0;
            fwdValidR <= 1'b0;
            fwdRwR    <= 5'd0;
            alignErrR <= 1'b0;
        end else if (wb.Stall) begin
            regWrR    <= validR & fwdValidR & ~writtenR;
            writtenR  <= validR;
            alignErrR <= 1'b0;
        end else begin
            validR       <= 1'b1;
            writtenR     <= 1'b1;
            busWR        <= selDataS;
            rwR          <= wb.InRW;
            regWrR       <= wrOkS;
            fwdValidR    <= wrOkS;
            fwdRwR       <= wb.InRW;
            alignErrR    <= misalignS;
            retireCountR <= retireCountR + 32'd1;
        end
    end

    assign wb.BusW        = busWR;
    assign wb.RW          = rwR;
    assign wb.RegWr       = regWrR;
    assign wb.FwdValid    = fwdValidR;
    assign wb.FwdRW       = fwdRwR;
    assign wb.AlignErr    = alignErrR;
    assign wb.RetireCount = retireCountR;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;
    import wb_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n;
    int errCount = 0;
    int checkCount = 0;
    logic [31:0] expRetire = 32'h0000_0000;

    writeback_stage_if bus();

    writeback_stage dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .wb      (bus)
    );

    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input logic regWr, input logic [4:0] rw, input logic [1:0] sel,
                         input logic [2:0] ld, input logic [1:0] addr, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [31:0] pc8);
        bus.InValid     = 1'b1;
        bus.InRegWr     = regWr;
        bus.InRW        = rw;
        bus.InWbSel     = sel;
        bus.InLdType    = ld;
        bus.InAddrLo    = addr;
        bus.InAluResult = alu;
        bus.InMemData   = mem;
        bus.InPcPlus8   = pc8;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present one instruction without stall/flush and let it land in the stage.
    task automatic present(input logic regWr, input logic [4:0] rw, input logic [1:0] sel,
                           input logic [2:0] ld, input logic [1:0] addr, input logic [31:0] alu,
                           input logic [31:0] mem, input logic [31:0] pc8);
        setIn(regWr, rw, sel, ld, addr, alu, mem, pc8);
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        tick();
        expRetire = expRetire + 32'd1;
        bus.InValid = 1'b0;
    endtask

    task automatic idle();
        bus.InValid = 1'b0;
        bus.Stall   = 1'b0;
        bus.Flush   = 1'b0;
        tick();
    endtask

    initial begin
        Reset_n = 1'b0;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        setIn(1'b0, 5'd0, 2'b00, 3'b000, 2'b00, 32'h0, 32'h0, 32'h0);
        bus.InValid = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        checkVal("rst_busw", bus.BusW, 32'h0);
        checkVal("rst_regwr", {31'd0, bus.RegWr}, 32'd0);
        checkVal("rst_fwdvalid", {31'd0, bus.FwdValid}, 32'd0);
        checkVal("rst_retire", bus.RetireCount, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();

        // Byte loads, signed and unsigned
        present(1'b1, 5'd5, WB_MEM, LD_LB, 2'b01, 32'h0, 32'h12F4_5678, 32'h0);
        checkVal("lb_busw", bus.BusW, 32'hFFFF_FFF4);
        checkVal("lb_regwr", {31'd0, bus.RegWr}, 32'd1);
        checkVal("lb_rw", {27'd0, bus.RW}, 32'd5);
        checkVal("lb_fwd", {26'd0, bus.FwdValid, bus.FwdRW}, {26'd0, 1'b1, 5'd5});
        checkVal("lb_retire", bus.RetireCount, expRetire);
        idle();
        checkVal("lb_regwr_gone", {31'd0, bus.RegWr}, 32'd0);
        present(1'b1, 5'd6, WB_MEM, LD_LBU, 2'b01, 32'h0, 32'h12F4_5678, 32'h0);
        checkVal("lbu_busw", bus.BusW, 32'h0000_00F4);
        present(1'b1, 5'd6, WB_MEM, LD_LB, 2'b11, 32'h0, 32'h1234_567F, 32'h0);
        checkVal("lb3_busw", bus.BusW, 32'h0000_007F);

        // Misaligned halfword
        present(1'b1, 5'd7, WB_MEM, LD_LH, 2'b01, 32'h0, 32'h1234_ABCD, 32'h0);
        checkVal("lh_mis_align", {31'd0, bus.AlignErr}, 32'd1);
        checkVal("lh_mis_regwr", {31'd0, bus.RegWr}, 32'd0);
        checkVal("lh_mis_fwd", {31'd0, bus.FwdValid}, 32'd0);
        checkVal("lh_mis_retire", bus.RetireCount, expRetire);
        idle();
        checkVal("lh_mis_pulse", {31'd0, bus.AlignErr}, 32'd0);

        // Halfwords, words, reserved select
        present(1'b1, 5'd8, WB_MEM, LD_LH, 2'b10, 32'h0, 32'h1234_ABCD, 32'h0);
        checkVal("lh_busw", bus.BusW, 32'hFFFF_ABCD);
        present(1'b1, 5'd8, WB_MEM, LD_LHU, 2'b00, 32'h0, 32'h1234_ABCD, 32'h0);
        checkVal("lhu_busw", bus.BusW, 32'h0000_1234);
        present(1'b1, 5'd8, WB_MEM, LD_LW, 2'b10, 32'h0, 32'h1234_ABCD, 32'h0);
        checkVal("lw_mis_align", {31'd0, bus.AlignErr}, 32'd1);
        present(1'b1, 5'd8, WB_MEM, 3'b111, 2'b00, 32'h0, 32'hDEAD_BEEF, 32'h0);
        checkVal("ldx_busw", bus.BusW, 32'hDEAD_BEEF);
        checkVal("ldx_align", {31'd0, bus.AlignErr}, 32'd0);
        present(1'b1, 5'd9, WB_RSVD, LD_LW, 2'b10, 32'hCAFE_0001, 32'h1, 32'h2);
        checkVal("rsvd_busw", bus.BusW, 32'hCAFE_0001);
        checkVal("rsvd_align", {31'd0, bus.AlignErr}, 32'd0);

        // Link write held by a 3-cycle stall
        present(1'b1, 5'd31, WB_LINK, LD_LW, 2'b00, 32'h1, 32'h2, 32'h0040_0008);
        checkVal("jal_regwr0", {31'd0, bus.RegWr}, 32'd1);
        checkVal("jal_busw0", bus.BusW, 32'h0040_0008);
        checkVal("jal_fwd0", {31'd0, bus.FwdValid}, 32'd1);
        setIn(1'b1, 5'd7, WB_ALU, LD_LW, 2'b00, 32'h7777_7777, 32'h0, 32'h0);
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal($sformatf("jal_stall%0d_regwr", i), {31'd0, bus.RegWr}, 32'd0);
            checkVal($sformatf("jal_stall%0d_busw", i), bus.BusW, 32'h0040_0008);
            checkVal($sformatf("jal_stall%0d_rw", i), {27'd0, bus.RW}, 32'd31);
            checkVal($sformatf("jal_stall%0d_fwd", i), {31'd0, bus.FwdValid}, 32'd1);
            checkVal($sformatf("jal_stall%0d_retire", i), bus.RetireCount, expRetire);
        end
        bus.Stall = 1'b0;

        // Writes to r0 are suppressed
        present(1'b1, 5'd0, WB_ALU, LD_LW, 2'b00, 32'h1111_2222, 32'h0, 32'h0);
        checkVal("r0_regwr", {31'd0, bus.RegWr}, 32'd0);
        checkVal("r0_fwd", {31'd0, bus.FwdValid}, 32'd0);
        checkVal("r0_retire", bus.RetireCount, expRetire);

        // Flush wins over stall
        present(1'b1, 5'd9, WB_ALU, LD_LW, 2'b00, 32'h0000_0011, 32'h0, 32'h0);
        checkVal("pre_flush_regwr", {31'd0, bus.RegWr}, 32'd1);
        setIn(1'b1, 5'd10, WB_ALU, LD_LW, 2'b00, 32'h22, 32'h0, 32'h0);
        bus.Stall = 1'b1;
        bus.Flush = 1'b1;
        tick();
        checkVal("flush_regwr", {31'd0, bus.RegWr}, 32'd0);
        checkVal("flush_rw", {27'd0, bus.RW}, 32'd0);
        checkVal("flush_fwd", {31'd0, bus.FwdValid}, 32'd0);
        checkVal("flush_retire", bus.RetireCount, expRetire);
        bus.Flush = 1'b0;
        bus.InValid = 1'b0;

        // Retire counter wrap, preset while the stage is stalled
        force dut.retireCountR = 32'hFFFF_FFFF;
        #1;
        release dut.retireCountR;
        expRetire = 32'hFFFF_FFFF;
        present(1'b1, 5'd3, WB_ALU, LD_LW, 2'b00, 32'h3, 32'h0, 32'h0);
        checkVal("wrap_zero", bus.RetireCount, 32'h0000_0000);
        present(1'b1, 5'd3, WB_ALU, LD_LW, 2'b00, 32'h3, 32'h0, 32'h0);
        checkVal("wrap_one", bus.RetireCount, 32'h0000_0001);

        // Asynchronous reset in the middle of a stall
        present(1'b1, 5'd12, WB_ALU, LD_LW, 2'b00, 32'h0000_0055, 32'h0, 32'h0);
        checkVal("pre_rst_regwr", {31'd0, bus.RegWr}, 32'd1);
        bus.InValid = 1'b1;
        bus.Stall = 1'b1;
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        checkVal("arst_busw", bus.BusW, 32'h0);
        checkVal("arst_rw", {27'd0, bus.RW}, 32'd0);
        checkVal("arst_fwd", {26'd0, bus.FwdValid, bus.FwdRW}, 32'd0);
        checkVal("arst_flags", {30'd0, bus.RegWr, bus.AlignErr}, 32'd0);
        checkVal("arst_retire", bus.RetireCount, 32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        checkVal("post_rst_regwr", {31'd0, bus.RegWr}, 32'd0);
        checkVal("post_rst_fwd", {31'd0, bus.FwdValid}, 32'd0);
        checkVal("post_rst_busw", bus.BusW, 32'h0);
        checkVal("post_rst_retire", bus.RetireCount, 32'h0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have port: Clk  input  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: Reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: InValid  input  1  MEM stage presents an instruction this cycle.
REQ-004 SHALL have port: Stall  input  1  hold current stage contents.
REQ-005 SHALL have port: Flush  input  1  replace captured instruction with a bubble.
REQ-006 SHALL have port: InRegWr  input  1  instruction writes a GPR.
REQ-007 SHALL have port: InRW  input  5  destination register.
REQ-008 SHALL have port: InWbSel  input  2  result source: 00 ALU, 01 MEM, 10 LINK, 11 reserved (treated as ALU).
REQ-009 SHALL have port: InLdType  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, others LW.
REQ-010 SHALL have port: InAddrLo  input  2  effective address bits [1:0].
REQ-011 SHALL have ports: InAluResult, InMemData, InPcPlus8  input  32 each  candidate results.
REQ-012 SHALL have ports: BusW  output  32, RW  output  5, RegWr  output  1  register-file write port (the register file writes on negedge Clk).
REQ-013 SHALL have ports: FwdValid  output  1, FwdRW  output  5  bypass tag to decode; bypass data equals BusW.
REQ-014 SHALL have port: AlignErr  output  1  one-cycle pulse on misaligned load.
REQ-015 SHALL have port: RetireCount  output  32  count of retired instructions.

Function
REQ-016 SHALL capture all In* fields on posedge Clk when Stall=0; latency one cycle from MEM to BusW/RW/RegWr.
REQ-017 SHALL give Flush priority over Stall: Flush=1 captures a bubble (valid=0) regardless of Stall.
REQ-018 SHALL, when Stall=1 and Flush=0, hold captured contents and BusW/RW unchanged.
REQ-019 SHALL assert RegWr only in the first cycle an instruction occupies the stage; stalled repeat cycles drive RegWr=0 (internal Written flag).
REQ-020 SHALL force RegWr=0 when captured RW=0, valid=0, InRegWr=0, or alignment error.
REQ-021 SHALL select BusW: ALU -> InAluResult; LINK -> InPcPlus8; MEM -> load-extended InMemData.
REQ-022 SHALL extract bytes big-endian: AddrLo 00 -> bits[31:24], 01 -> [23:16], 10 -> [15:8], 11 -> [7:0]; halfwords: AddrLo[1]=0 -> [31:16], 1 -> [15:0].
REQ-023 SHALL sign-extend LB/LH and zero-extend LBU/LHU to 32 bits; LW passes data unmodified.
REQ-024 SHALL flag misalignment for MEM-sourced LW with AddrLo!=00 and LH/LHU with AddrLo[0]=1; AlignErr pulses in the first cycle only.
REQ-025 SHALL drive FwdValid=1 while a valid, non-faulting, RegWr-type instruction with RW!=0 occupies the stage (including stalled cycles), FwdRW=RW.
REQ-026 SHALL increment RetireCount by one in each cycle a valid instruction is first presented (faulting or not), wrapping 0xFFFFFFFF -> 0.

Reset
REQ-027 SHALL on Reset_n=0 immediately clear valid, Written, BusW=0, RW=0, RegWr=0, FwdValid=0, FwdRW=0, AlignErr=0, RetireCount=0.
REQ-028 SHALL, on reset asserted mid-stall, discard the held instruction; first posedge after release behaves as an empty stage.

Structure
REQ-029 SHALL place WbSel and LdType encodings and width constants in the shared package wb_pkg.
REQ-030 SHALL implement byte/half extraction and extension in one combinational sub-module load_extender.

Verification
REQ-031 SHALL cover: LB, InMemData=0x12F45678, AddrLo=01 -> BusW=0xFFFFFFF4, RegWr=1 one cycle; LBU same -> 0x000000F4.
REQ-032 SHALL cover: LH, AddrLo=01 -> AlignErr=1 one cycle, RegWr=0, FwdValid=0, RetireCount+1.
REQ-033 SHALL cover: JAL-style LINK, RW=31, InPcPlus8=0x00400008, Stall held 3 cycles -> RegWr=1 first cycle only, BusW stable 0x00400008, FwdValid=1 all 4 cycles.
REQ-034 SHALL cover: InRW=0 with InRegWr=1 -> RegWr=0, FwdValid=0; Flush with Stall=1 -> next cycle RegWr=0, RW=0 bubble.
REQ-035 SHALL cover: RetireCount preset via 2^32-1 retirements (or forced) -> next retirement yields 0; Reset_n pulsed low mid-cycle -> all outputs 0 asynchronously.
